snake_mover: RTL and testbench

Sequencer that sits directly upstream of the 226-entry snake position register file and drives its `value_in`/`index`/`enable` write port. It loads the initial snake after reset, and on each game tick it shifts every body segment one slot toward the tail and writes a new head computed from the current direction. It reads the register file's flattened `value_out` bus back as its data source. Each 32-bit entry encodes one segment: x in bits [31:16], y in bits [15:0], and entry 0 is the head.

---
 rtl/snake_mover.sv | 177 +++++++++++++++++
 tb/tb_snake_mover.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_mover.sv
// rtl/snake_mover.sv - snake body sequencer driving the position register file write port
module snake_mover #(
    parameter int MAX_LEN  = 226,
    parameter int WIDTH    = 40,
    parameter int HEIGHT   = 30,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 20,
    parameter int START_Y  = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [1:0]            dir_in,
    input  logic                  grow,
    input  logic [MAX_LEN*32-1:0] snake_in,
    output logic [31:0]           value_out,
    output logic [31:0]           index,
    output logic                  enable,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            length,
    output logic [31:0]           head
);

    localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [15:0] SX   = 16'(START_X);
    localparam logic [15:0] SY   = 16'(START_Y);
    localparam logic [15:0] XMAX = 16'(WIDTH - 1);
    localparam logic [15:0] YMAX = 16'(HEIGHT - 1);

    localparam logic [7:0] LEN_MAX  = 8'(MAX_LEN);
    localparam logic [7:0] LEN_INIT = 8'(INIT_LEN);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SHIFT,
        ST_HEAD,
        ST_DONE
    } state_t;

    state_t      state;
    logic [7:0]  init_cnt;
    logic [7:0]  i_cnt;
    logic [1:0]  last_dir;
    logic [1:0]  eff_dir;
    logic [7:0]  new_len;
    logic [31:0] new_head;

    // Unflattened view of the register file read bus
    logic [31:0] entry [MAX_LEN];

    genvar g;
    generate
        for (g = 0; g < MAX_LEN; g++) begin : g_unpack
            assign entry[g] = snake_in[32*g +: 32];
        end
    endgenerate

    logic        accept;
    logic        reverse;
    logic [1:0]  sel_dir;
    logic [7:0]  grow_len;
    logic [15:0] cur_x;
    logic [15:0] cur_y;
    logic [15:0] nx;
    logic [15:0] ny;
    logic [IDXW-1:0] src_idx;

    // A tick is only taken once the previous operation has fully retired
    assign accept   = (state == ST_IDLE) && !busy && tick;
    // Opposite directions differ only in bit 1 (up/down, right/left)
    assign reverse  = (dir_in == {~last_dir[1], last_dir[0]});
    assign sel_dir  = reverse ? last_dir : dir_in;
    assign grow_len = (grow && (length < LEN_MAX)) ? length + 8'd1 : length;
    assign cur_x    = entry[0][31:16];
    assign cur_y    = entry[0][15:0];
    assign src_idx  = IDXW'(i_cnt - 8'd1);

    // Next head position from the current head with toroidal wrap per axis
    always_comb begin
        nx = cur_x;
        ny = cur_y;
        case (sel_dir)
            DIR_UP:    ny = (cur_y == 16'd0) ? YMAX : cur_y - 16'd1;
            DIR_RIGHT: nx = (cur_x == XMAX) ? 16'd0 : cur_x + 16'd1;
            DIR_DOWN:  ny = (cur_y == YMAX) ? 16'd0 : cur_y + 16'd1;
            DIR_LEFT:  nx = (cur_x == 16'd0) ? XMAX : cur_x - 16'd1;
            default:   nx = cur_x;
        endcase
    end

    // Sequencer: initial load, tail-first body shift, head write, done pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_INIT;
            init_cnt  <= 8'd0;
            i_cnt     <= 8'd0;
            value_out <= 32'd0;
            index     <= 32'd0;
            enable    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            length    <= LEN_INIT;
            head      <= {SX, SY};
            last_dir  <= DIR_RIGHT;
            eff_dir   <= DIR_RIGHT;
            new_len   <= LEN_INIT;
            new_head  <= {SX, SY};
        end else begin
            case (state)
                ST_INIT: begin
                    value_out <= {SX - 16'(init_cnt), SY};
                    index     <= 32'(init_cnt);
                    enable    <= 1'b1;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    if (init_cnt == LEN_INIT - 8'd1) begin
                        init_cnt <= 8'd0;
                        state    <= ST_IDLE;
                    end else begin
                        init_cnt <= init_cnt + 8'd1;
                    end
                end
                ST_IDLE: begin
                    enable <= 1'b0;
                    done   <= 1'b0;
                    if (accept) begin
                        eff_dir  <= sel_dir;
                        new_len  <= grow_len;
                        new_head <= {nx, ny};
                        i_cnt    <= grow_len - 8'd1;
                        busy     <= 1'b1;
                        state    <= (grow_len == 8'd1) ? ST_HEAD : ST_SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // Entry i-1 is read before the later write to it overwrites it
                    value_out <= entry[src_idx];
                    index     <= 32'(i_cnt);
                    enable    <= 1'b1;
                    i_cnt     <= i_cnt - 8'd1;
                    if (i_cnt == 8'd1) begin
                        state <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    value_out <= new_head;
                    index     <= 32'd0;
                    enable    <= 1'b1;
                    head      <= new_head;
                    last_dir  <= eff_dir;
                    length    <= new_len;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    enable <= 1'b0;
                    done   <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    enable <= 1'b0;
                    state  <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_mover.sv
// tb/tb_snake_mover.sv - directed table-driven bench for snake_mover
module tb_snake_mover;

    localparam int MAX_LEN = 226;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  tick = 1'b0;
    logic [1:0]            dir_in = 2'b01;
    logic                  grow = 1'b0;
    logic [MAX_LEN*32-1:0] snake_in;
    logic [31:0]           value_out;
    logic [31:0]           index;
    logic                  enable;
    logic                  busy;
    logic                  done;
    logic [7:0]            length;
    logic [31:0]           head;

    int passed = 0;
    int total  = 0;

    snake_mover dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .dir_in    (dir_in),
        .grow      (grow),
        .snake_in  (snake_in),
        .value_out (value_out),
        .index     (index),
        .enable    (enable),
        .busy      (busy),
        .done      (done),
        .length    (length),
        .head      (head)
    );

    always #5 clock = ~clock;

    // Register file model: plain edge-written array
    logic [31:0] mem [MAX_LEN];
    always @(posedge clock) begin
        if (enable && index < MAX_LEN) mem[index] <= value_out;
    end

    genvar g;
    generate
        for (g = 0; g < MAX_LEN; g++) begin : g_pack
            assign snake_in[32*g +: 32] = mem[g];
        end
    endgenerate

    // Write log ring and done counter
    logic [31:0] wr_idx [8];
    logic [31:0] wr_val [8];
    int wr_total = 0;
    int done_total = 0;
    always @(posedge clock) begin
        if (enable) begin
            wr_idx[wr_total[2:0]] <= index;
            wr_val[wr_total[2:0]] <= value_out;
            wr_total <= wr_total + 1;
        end
        if (done) done_total <= done_total + 1;
    end

    typedef struct {
        logic [1:0] dir;
        logic       grw;
        int         ex;
        int         ey;
        int         elen;
    } vec_t;

    vec_t vt [8];

    function automatic logic [31:0] pos(input int x, input int y);
        return {16'(x), 16'(y)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_move(input logic [1:0] d, input logic gr, output int lat, output int nwr, output int w0);
        @(negedge clock);
        dir_in = d;
        grow   = gr;
        tick   = 1'b1;
        w0     = wr_total;
        @(posedge clock);
        #1;
        tick = 1'b0;
        grow = 1'b0;
        lat  = 0;
        while (!done && lat < 400) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!done) check("move_timeout", 64'd0, 64'd1);
        nwr = wr_total - w0;
        @(posedge clock);
        #1;
    endtask

    task automatic move_check(input string name, input logic [1:0] d, input logic gr,
                              input int ex, input int ey, input int elen);
        int lat, nwr, w0;
        do_move(d, gr, lat, nwr, w0);
        check({name, "_head"}, head, pos(ex, ey));
        check({name, "_len"}, length, elen);
        check({name, "_lat"}, lat, elen + 1);
    endtask

    initial begin
        int lat, nwr, w0, n, d0;
        logic [31:0] prev;

        vt[0] = '{2'b01, 1'b0, 21, 15, 3};
        vt[1] = '{2'b11, 1'b0, 22, 15, 3};
        vt[2] = '{2'b11, 1'b0, 23, 15, 3};
        vt[3] = '{2'b00, 1'b0, 23, 14, 3};
        vt[4] = '{2'b10, 1'b0, 23, 13, 3};
        vt[5] = '{2'b11, 1'b1, 22, 13, 4};
        vt[6] = '{2'b01, 1'b0, 21, 13, 4};
        vt[7] = '{2'b10, 1'b1, 21, 14, 5};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_enable", enable, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_length", length, 3);
        check("rst_head", head, pos(20, 15));
        check("rst_index", index, 0);
        check("rst_value", value_out, 0);

        // Initial load
        @(negedge clock);
        reset = 1'b1;
        w0 = wr_total;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (busy && n < 50);
        check("init_busy", busy, 0);
        check("init_nwr", wr_total - w0, 3);
        for (int k = 0; k < 3; k++) begin
            check("init_idx", wr_idx[3'(w0 + k)], k);
            check("init_val", wr_val[3'(w0 + k)], pos(20 - k, 15));
        end
        check("init_len", length, 3);
        check("init_enable", enable, 0);

        // Table of moves
        prev = pos(20, 15);
        for (int i = 0; i < 8; i++) begin
            do_move(vt[i].dir, vt[i].grw, lat, nwr, w0);
            check("vec_head", head, pos(vt[i].ex, vt[i].ey));
            check("vec_len", length, vt[i].elen);
            check("vec_lat", lat, vt[i].elen + 1);
            check("vec_nwr", nwr, vt[i].elen);
            check("vec_mem0", mem[0], pos(vt[i].ex, vt[i].ey));
            check("vec_mem1", mem[1], prev);
            check("vec_idle", {busy, done, enable}, 3'b000);
            if (i == 0) begin
                check("mv0_idx0", wr_idx[3'(w0)], 2);
                check("mv0_val0", wr_val[3'(w0)], pos(19, 15));
                check("mv0_idx1", wr_idx[3'(w0 + 1)], 1);
                check("mv0_val1", wr_val[3'(w0 + 1)], pos(20, 15));
                check("mv0_idx2", wr_idx[3'(w0 + 2)], 0);
                check("mv0_val2", wr_val[3'(w0 + 2)], pos(21, 15));
            end
            prev = pos(vt[i].ex, vt[i].ey);
        end

        // Edge wraps on both axes
        repeat (17) do_move(2'b01, 1'b0, lat, nwr, w0);
        move_check("to_x39", 2'b01, 1'b0, 39, 14, 5);
        move_check("wrap_right", 2'b01, 1'b0, 0, 14, 5);
        repeat (13) do_move(2'b00, 1'b0, lat, nwr, w0);
        move_check("to_y0", 2'b00, 1'b0, 0, 0, 5);
        move_check("wrap_up", 2'b00, 1'b0, 0, 29, 5);
        move_check("wrap_left", 2'b11, 1'b0, 39, 29, 5);
        move_check("wrap_down", 2'b10, 1'b0, 39, 0, 5);

        // Tick while busy is dropped
        @(negedge clock);
        dir_in = 2'b01;
        tick = 1'b1;
        @(posedge clock);
        #1;
        tick = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        dir_in = 2'b10;
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("busy_tick_done", done, 1);
        d0 = done_total;
        w0 = wr_total;
        repeat (15) @(posedge clock);
        #1;
        check("busy_tick_nodone", done_total, d0 + 1);
        check("busy_tick_nowr", wr_total, w0);
        check("busy_tick_head", head, pos(0, 0));

        // Grow to the length limit
        n = 0;
        while (length < 8'd226 && n < 300) begin
            do_move(2'b01, 1'b1, lat, nwr, w0);
            n++;
        end
        check("max_len_reached", length, 226);
        do_move(2'b01, 1'b1, lat, nwr, w0);
        check("max_len_hold", length, 226);
        check("max_nwr", nwr, 226);
        check("max_lat", lat, 227);

        // Reset during SHIFT, tick during INIT
        @(negedge clock);
        dir_in = 2'b01;
        tick = 1'b1;
        @(posedge clock);
        #1;
        tick = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_enable", enable, 0);
        check("midrst_busy", busy, 1);
        check("midrst_len", length, 3);
        check("midrst_head", head, pos(20, 15));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        d0 = done_total;
        @(negedge clock);
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("reinit_busy", busy, 0);
        repeat (20) @(posedge clock);
        #1;
        check("reinit_nomove", done_total, d0);
        for (int k = 0; k < 3; k++) check("reinit_mem", mem[k], pos(20 - k, 15));
        check("reinit_len", length, 3);
        move_check("post_reset", 2'b01, 1'b0, 21, 15, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
